// File: rtl/miso_delay_calibrator_if.sv
// Probe-transaction handshake between the delay calibrator and the SPI engine.
// The calibrator is the master: it raises spi_req, the engine answers with spi_ack and miso_word.
interface miso_delay_calibrator_if;
    logic        spi_req;
    logic        spi_ack;
    logic [15:0] miso_word;

    modport master (output spi_req, input spi_ack, input miso_word);
    modport slave  (input spi_req, output spi_ack, output miso_word);
endinterface

// File: rtl/miso_delay_calibrator.sv
// MISO cable-delay calibrator: sweeps phase_select, probes each delay with a known reply and
// centres delay_out in the longest passing window. Optional ack watchdog: MISO_CAL_TIMEOUT_EN.
module miso_delay_calibrator #(
    parameter int unsigned NUM_DELAYS    = 12,
    parameter logic [15:0] EXPECTED      = 16'h0049,
    parameter int unsigned REPEATS       = 4,
    parameter int unsigned SETTLE_CYCLES = 2
`ifdef MISO_CAL_TIMEOUT_EN
   ,parameter int unsigned TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic                     dataclk,
    input  logic                     rst_n,
    input  logic                     start,
    miso_delay_calibrator_if.master  spi,
    output logic [3:0]               delay_out,
    output logic                     busy,
    output logic                     done,
    output logic                     cal_ok,
    output logic [3:0]               best_delay,
    output logic [15:0]              pass_mask
`ifdef MISO_CAL_TIMEOUT_EN
   ,output logic                     timeout_err
`endif
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        REQ,
        CHECK,
        NEXT,
        EVAL
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          d_q, d_d;
    logic [3:0]          rep_q, rep_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [15:0]         word_q, word_d;
    logic                cur_pass_q, cur_pass_d;
    logic [15:0]         pass_mask_q, pass_mask_d;
    logic [4:0]          run_len_q, run_len_d;
    logic [4:0]          run_start_q, run_start_d;
    logic [4:0]          best_len_q, best_len_d;
    logic [4:0]          best_start_q, best_start_d;
    logic [3:0]          restore_q, restore_d;
    logic [3:0]          delay_out_q, delay_out_d;
    logic [3:0]          best_delay_q, best_delay_d;
    logic                cal_ok_q, cal_ok_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
`ifdef MISO_CAL_TIMEOUT_EN
    logic [15:0]         wd_q, wd_d;
    logic                timeout_err_q, timeout_err_d;
`endif

    always_comb begin
        state_d      = state_q;
        d_d          = d_q;
        rep_d        = rep_q;
        settle_d     = settle_q;
        word_d       = word_q;
        cur_pass_d   = cur_pass_q;
        pass_mask_d  = pass_mask_q;
        run_len_d    = run_len_q;
        run_start_d  = run_start_q;
        best_len_d   = best_len_q;
        best_start_d = best_start_q;
        restore_d    = restore_q;
        delay_out_d  = delay_out_q;
        best_delay_d = best_delay_q;
        cal_ok_d     = cal_ok_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
`ifdef MISO_CAL_TIMEOUT_EN
        // Watchdog runs only while a request is outstanding and restarts with every request.
        wd_d          = (state_q == REQ) ? wd_q + 16'd1 : 16'd0;
        timeout_err_d = timeout_err_q;
`endif

        case (state_q)
            IDLE: begin
                // The done cycle still counts as the tail of the previous run.
                if (start && !done_q) begin
                    restore_d    = delay_out_q;
                    pass_mask_d  = 16'd0;
                    run_len_d    = 5'd0;
                    run_start_d  = 5'd0;
                    best_len_d   = 5'd0;
                    best_start_d = 5'd0;
                    d_d          = 4'd0;
                    delay_out_d  = 4'd0;
                    rep_d        = 4'd0;
                    settle_d     = '0;
                    busy_d       = 1'b1;
`ifdef MISO_CAL_TIMEOUT_EN
                    timeout_err_d = 1'b0;
`endif
                    state_d      = SETTLE;
                end
            end

            SETTLE: begin
                if (32'(settle_q) + 32'd1 >= SETTLE_CYCLES) begin
                    settle_d = '0;
                    state_d  = REQ;
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end

            REQ: begin
                if (spi.spi_ack) begin
                    word_d  = spi.miso_word;
                    state_d = CHECK;
                end
`ifdef MISO_CAL_TIMEOUT_EN
                else if (wd_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    cur_pass_d    = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = NEXT;
                end
`endif
            end

            CHECK: begin
                if (word_q != EXPECTED) begin
                    cur_pass_d = 1'b0;
                    state_d    = NEXT;
                end else if (32'(rep_q) + 32'd1 < REPEATS) begin
                    rep_d   = rep_q + 4'd1;
                    state_d = REQ;
                end else begin
                    cur_pass_d = 1'b1;
                    state_d    = NEXT;
                end
            end

            NEXT: begin
                pass_mask_d[d_q] = cur_pass_q;
                if (cur_pass_q) begin
                    if (run_len_q == 5'd0) begin
                        run_start_d = {1'b0, d_q};
                    end
                    run_len_d = run_len_q + 5'd1;
                end else begin
                    run_len_d = 5'd0;
                end
                // Strictly greater: an equal-length later window never displaces the earlier one.
                if (run_len_d > best_len_q) begin
                    best_len_d   = run_len_d;
                    best_start_d = run_start_d;
                end
                if (d_q == 4'(NUM_DELAYS - 1)) begin
                    state_d = EVAL;
                end else begin
                    d_d         = d_q + 4'd1;
                    delay_out_d = d_q + 4'd1;
                    rep_d       = 4'd0;
                    settle_d    = '0;
                    state_d     = SETTLE;
                end
            end

            EVAL: begin
                if (best_len_q != 5'd0) begin
                    best_delay_d = 4'(best_start_q + ((best_len_q - 5'd1) >> 1));
                    delay_out_d  = 4'(best_start_q + ((best_len_q - 5'd1) >> 1));
                    cal_ok_d     = 1'b1;
                end else begin
                    cal_ok_d    = 1'b0;
                    delay_out_d = restore_q;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge dataclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            d_q          <= 4'd0;
            rep_q        <= 4'd0;
            settle_q     <= '0;
            word_q       <= 16'd0;
            cur_pass_q   <= 1'b0;
            pass_mask_q  <= 16'd0;
            run_len_q    <= 5'd0;
            run_start_q  <= 5'd0;
            best_len_q   <= 5'd0;
            best_start_q <= 5'd0;
            restore_q    <= 4'd0;
            delay_out_q  <= 4'd0;
            best_delay_q <= 4'd0;
            cal_ok_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef MISO_CAL_TIMEOUT_EN
            wd_q          <= 16'd0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            d_q          <= d_d;
            rep_q        <= rep_d;
            settle_q     <= settle_d;
            word_q       <= word_d;
            cur_pass_q   <= cur_pass_d;
            pass_mask_q  <= pass_mask_d;
            run_len_q    <= run_len_d;
            run_start_q  <= run_start_d;
            best_len_q   <= best_len_d;
            best_start_q <= best_start_d;
            restore_q    <= restore_d;
            delay_out_q  <= delay_out_d;
            best_delay_q <= best_delay_d;
            cal_ok_q     <= cal_ok_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef MISO_CAL_TIMEOUT_EN
            wd_q          <= wd_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    // Request follows the state directly so an async reset withdraws it at once.
    assign spi.spi_req = (state_q == REQ);
    assign delay_out   = delay_out_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cal_ok      = cal_ok_q;
    assign best_delay  = best_delay_q;
    assign pass_mask   = pass_mask_q;
`ifdef MISO_CAL_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`endif

endmodule
